// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus slave port among NUM_M pulse-driven masters.
// One transaction in flight at a time; hung slaves are terminated by a timeout error.
module sys_bus_arbiter #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_M*AW-1:0] s_addr_i,
  input  logic [NUM_M*DW-1:0] s_wdata_i,
  input  logic [NUM_M-1:0]    s_wen_i,
  input  logic [NUM_M-1:0]    s_ren_i,
  output logic [NUM_M-1:0]    s_ack_o,
  output logic [NUM_M-1:0]    s_err_o,
  output logic [DW-1:0]       s_rdata_o,
  output logic [NUM_M-1:0]    s_ovf_o,
  output logic [AW-1:0]       m_addr_o,
  output logic [DW-1:0]       m_wdata_o,
  output logic                m_wen_o,
  output logic                m_ren_o,
  input  logic                m_ack_i,
  input  logic                m_err_i,
  input  logic [DW-1:0]       m_rdata_i
);

  localparam int unsigned   GW          = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned   CW          = $clog2(TIMEOUT + 2);
  localparam logic [GW:0]   NumM        = (GW + 1)'(NUM_M);
  localparam logic [GW-1:0] LastM       = GW'(NUM_M - 1);
  localparam logic [DW-1:0] TimeoutData = DW'(32'hDEADBEEF);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e r_state, w_state_d;

  logic [AW-1:0]    r_addr  [NUM_M];
  logic [DW-1:0]    r_wdata [NUM_M];
  logic [NUM_M-1:0] r_we, r_pend, r_ovf;
  logic [GW-1:0]    r_rr, r_g;
  logic [AW-1:0]    r_maddr;
  logic [DW-1:0]    r_mwdata, r_rdata;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic [NUM_M-1:0]   w_req, w_sel, w_clr, w_rot;
  logic [2*NUM_M-1:0] w_dbl;
  logic [GW-1:0]      w_off, w_gnt;
  logic [GW:0]        w_sum;
  logic               w_any, w_done, w_tmo;

  assign w_req  = s_wen_i | s_ren_i;
  assign w_done = m_ack_i | m_err_i;
  assign w_tmo  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign w_sel  = NUM_M'(1) << r_g;
  assign w_clr  = (r_state == StResp) ? w_sel : '0;

  // Rotate pending so index rr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    w_dbl = {r_pend, r_pend} >> r_rr;
    w_rot = w_dbl[NUM_M-1:0];
    w_off = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = GW'(i);
    end
    w_any = |r_pend;
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    w_gnt = (w_sum >= NumM) ? GW'(w_sum - NumM) : GW'(w_sum);
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_any) w_state_d = StIssue;
      StIssue: w_state_d = w_done ? StResp : StWait;
      StWait:  if (w_done || w_tmo) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_rr     <= '0;
      r_g      <= '0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_g      <= w_gnt;
            r_maddr  <= r_addr[w_gnt];
            r_mwdata <= r_wdata[w_gnt];
          end
        end
        StIssue: begin
          r_cnt <= '0;
          if (w_done) begin
            r_rdata <= m_rdata_i;
            r_err   <= m_err_i;
          end
        end
        StWait: begin
          if (w_done) begin
            r_rdata <= m_rdata_i;
            r_err   <= m_err_i;
          end else if (w_tmo) begin
            r_rdata <= TimeoutData;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StResp: r_rr <= (r_g == LastM) ? '0 : r_g + GW'(1);
        default: ;
      endcase
    end
  end

  // A master may re-request in its own RESP cycle since its slot frees on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovf  <= '0;
      r_we   <= '0;
      for (int k = 0; k < NUM_M; k++) begin
        r_addr[k]  <= '0;
        r_wdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        if (w_req[k] && (!r_pend[k] || w_clr[k])) begin
          r_pend[k]  <= 1'b1;
          r_we[k]    <= s_wen_i[k];
          r_addr[k]  <= s_addr_i[k*AW +: AW];
          r_wdata[k] <= s_wdata_i[k*DW +: DW];
        end else begin
          if (w_req[k]) r_ovf[k] <= 1'b1;
          if (w_clr[k]) r_pend[k] <= 1'b0;
        end
      end
    end
  end

  assign s_ack_o   = w_clr;
  assign s_err_o   = w_clr & {NUM_M{r_err}};
  assign s_rdata_o = r_rdata;
  assign s_ovf_o   = r_ovf;
  assign m_addr_o  = r_maddr;
  assign m_wdata_o = r_mwdata;
  assign m_wen_o   = (r_state == StIssue) && r_we[r_g];
  assign m_ren_o   = (r_state == StIssue) && !r_we[r_g];

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sys_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N*AW-1:0] s_addr_i;
  logic [N*DW-1:0] s_wdata_i;
  logic [N-1:0]    s_wen_i, s_ren_i;
  logic [N-1:0]    s_ack_o, s_err_o, s_ovf_o;
  logic [DW-1:0]   s_rdata_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic            m_wen_o, m_ren_o;
  logic            m_ack_i, m_err_i;
  logic [DW-1:0]   m_rdata_i;

  always #5 clk_i = ~clk_i;

  sys_bus_arbiter #(
    .NUM_M  (N),
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_addr_i (s_addr_i),
    .s_wdata_i(s_wdata_i),
    .s_wen_i  (s_wen_i),
    .s_ren_i  (s_ren_i),
    .s_ack_o  (s_ack_o),
    .s_err_o  (s_err_o),
    .s_rdata_o(s_rdata_o),
    .s_ovf_o  (s_ovf_o),
    .m_addr_o (m_addr_o),
    .m_wdata_o(m_wdata_o),
    .m_wen_o  (m_wen_o),
    .m_ren_o  (m_ren_o),
    .m_ack_i  (m_ack_i),
    .m_err_i  (m_err_i),
    .m_rdata_i(m_rdata_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: per-master slots plus the timeline of the one transaction in flight.
  bit          mp  [N];
  bit          mwe [N];
  bit          movf[N];
  logic [31:0] ma  [N];
  logic [31:0] mw  [N];
  int          rr, g, issue_at, resp_at;
  bit          busy, rknown, rerr, g_we;
  logic [31:0] last_rd, e_maddr, e_mwd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mp[k] = 0; mwe[k] = 0; movf[k] = 0; ma[k] = '0; mw[k] = '0;
    end
    rr = 0; g = 0; issue_at = 0; resp_at = 0;
    busy = 0; rknown = 0; rerr = 0; g_we = 0;
    last_rd = '0; e_maddr = '0; e_mwd = '0;
  endtask

  task automatic check_model();
    logic [N-1:0] e_ack, e_err, e_ovf;
    e_ack = '0;
    if (busy && rknown && cyc == resp_at) e_ack[g] = 1'b1;
    e_err = rerr ? e_ack : '0;
    for (int k = 0; k < N; k++) e_ovf[k] = movf[k];
    chk("s_ack_o",   64'(s_ack_o),   64'(e_ack));
    chk("s_err_o",   64'(s_err_o),   64'(e_err));
    chk("s_ovf_o",   64'(s_ovf_o),   64'(e_ovf));
    chk("s_rdata_o", 64'(s_rdata_o), 64'(last_rd));
    chk("m_addr_o",  64'(m_addr_o),  64'(e_maddr));
    chk("m_wdata_o", 64'(m_wdata_o), 64'(e_mwd));
    chk("m_wen_o",   64'(m_wen_o),   64'(busy && cyc == issue_at && g_we));
    chk("m_ren_o",   64'(m_ren_o),   64'(busy && cyc == issue_at && !g_we));
  endtask

  task automatic model_update();
    bit was_busy, clr, found;
    bit relatch[N];
    if (rst_i) begin
      model_reset();
      return;
    end
    was_busy = busy;
    clr      = busy && rknown && cyc == resp_at;
    if (busy && !rknown && cyc >= issue_at) begin
      if (m_ack_i || m_err_i) begin
        rknown = 1; resp_at = cyc + 1; rerr = m_err_i; last_rd = m_rdata_i;
      end else if (TMO != 0 && cyc == issue_at + TMO) begin
        rknown = 1; resp_at = cyc + 1; rerr = 1; last_rd = 32'hDEADBEEF;
      end
    end
    if (!was_busy) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        int k = (rr + i) % N;
        if (!found && mp[k]) begin
          found = 1; g = k;
        end
      end
      if (found) begin
        busy = 1; rknown = 0; issue_at = cyc + 1;
        e_maddr = ma[g]; e_mwd = mw[g]; g_we = mwe[g];
      end
    end
    for (int k = 0; k < N; k++) begin
      relatch[k] = 0;
      if (s_wen_i[k] || s_ren_i[k]) begin
        if (!mp[k] || (clr && g == k)) begin
          mp[k] = 1; mwe[k] = s_wen_i[k]; relatch[k] = 1;
          ma[k] = s_addr_i[k*AW +: AW]; mw[k] = s_wdata_i[k*DW +: DW];
        end else begin
          movf[k] = 1;
        end
      end
    end
    if (clr) begin
      if (!relatch[g]) mp[g] = 0;
      busy = 0;
      rr = (g + 1) % N;
    end
  endtask

  // One clock cycle: compare, advance model with this cycle's inputs, clock, clear pulses.
  task automatic step();
    check_model();
    model_update();
    @(posedge clk_i);
    #1;
    cyc++;
    s_wen_i = '0; s_ren_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic set_req(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (we) s_wen_i[k] = 1'b1;
    else    s_ren_i[k] = 1'b1;
    s_addr_i[k*AW +: AW]  = a;
    s_wdata_i[k*DW +: DW] = d;
  endtask

  function automatic int ack_idx(input logic [N-1:0] a);
    for (int k = 0; k < N; k++) if (a[k]) return k;
    return -1;
  endfunction

  initial begin
    int order[$];
    int exp_order[6];
    int n, c_wen, c_ack, acks;
    bit seen0, seen2;

    rst_i = 1'b1; s_addr_i = '0; s_wdata_i = '0; s_wen_i = '0; s_ren_i = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;
    @(posedge clk_i);
    #1;
    model_reset();
    rst_i = 1'b0;
    chk("reset s_ack_o", 64'(s_ack_o), 64'(0));
    chk("reset s_ovf_o", 64'(s_ovf_o), 64'(0));
    chk("reset m_strobes", 64'({m_wen_o, m_ren_o}), 64'(0));
    chk("reset m_addr_o", 64'(m_addr_o), 64'(0));

    // Single read with documented latency.
    set_req(1, 0, 32'h40000010, 32'h0);
    step();
    step();
    chk("read m_ren_o@2", 64'(m_ren_o), 64'(1));
    chk("read m_addr_o", 64'(m_addr_o), 64'h40000010);
    step();
    m_ack_i = 1'b1; m_rdata_i = 32'h12345678;
    step();
    chk("read s_ack_o@4", 64'(s_ack_o), 64'(4'b0010));
    chk("read s_rdata_o", 64'(s_rdata_o), 64'h12345678);
    chk("read s_err_o", 64'(s_err_o), 64'(0));
    step();

    // Fairness, ISSUE-cycle ack, and re-request in own RESP cycle.
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1, 32'h1000 + k, 32'hA0 + k);
    step();
    seen0 = 0; seen2 = 0; c_wen = -1; c_ack = -1;
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      if (m_wen_o && c_wen < 0) c_wen = cyc;
      if (s_ack_o != '0) begin
        if (c_ack < 0) c_ack = cyc;
        order.push_back(ack_idx(s_ack_o));
        if (s_ack_o[0] && !seen0) begin seen0 = 1; set_req(0, 1, 32'h2000, 32'hB0); end
        if (s_ack_o[2] && !seen2) begin seen2 = 1; set_req(2, 1, 32'h2002, 32'hB2); end
      end
      m_ack_i = 1'b1;
      step();
    end
    exp_order = '{0, 1, 2, 3, 0, 2};
    chk("fair grant count", 64'(order.size()), 64'(6));
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("fair grant[%0d]", i), 64'(order[i]), 64'(exp_order[i]));
    chk("issue-ack latency", 64'(c_ack - c_wen), 64'(1));
    chk("resp re-request no ovf", 64'(s_ovf_o), 64'(0));

    // Overflow: second pulse while pending is dropped and sticky.
    do_reset();
    set_req(2, 0, 32'h3000, 32'h0);
    step();
    set_req(2, 0, 32'h3004, 32'h0);
    step();
    chk("ovf set", 64'(s_ovf_o), 64'(4'b0100));
    m_ack_i = 1'b1; m_rdata_i = 32'hCAFE0002;
    step();
    chk("ovf first ack", 64'(s_ack_o), 64'(4'b0100));
    chk("ovf first rdata", 64'(s_rdata_o), 64'hCAFE0002);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_ren_o || m_wen_o) n++;
      step();
    end
    chk("ovf dropped req", 64'(n), 64'(0));
    chk("ovf sticky", 64'(s_ovf_o), 64'(4'b0100));

    // Timeout after exactly TMO WAIT cycles, then a stray ack while idle.
    do_reset();
    set_req(3, 0, 32'h4000, 32'h0);
    step();
    for (int i = 0; i < 10 && !m_ren_o; i++) step();
    chk("tmo issue seen", 64'(m_ren_o), 64'(1));
    n = 0;
    for (int i = 0; i < 40 && s_ack_o == '0; i++) begin
      step();
      n++;
    end
    chk("tmo ack delay", 64'(n), 64'(TMO + 1));
    chk("tmo s_ack_o", 64'(s_ack_o), 64'(4'b1000));
    chk("tmo s_err_o", 64'(s_err_o), 64'(4'b1000));
    chk("tmo s_rdata_o", 64'(s_rdata_o), 64'hDEADBEEF);
    step();
    m_ack_i = 1'b1; m_rdata_i = 32'h55;
    step();
    chk("idle ack ignored", 64'(s_ack_o), 64'(0));
    chk("idle rdata held", 64'(s_rdata_o), 64'hDEADBEEF);

    // Reset mid-WAIT abandons the transaction and restarts rr at 0.
    do_reset();
    set_req(2, 0, 32'h5000, 32'h0);
    for (int i = 0; i < 4; i++) step();
    do_reset();
    chk("rst strobes", 64'({m_wen_o, m_ren_o}), 64'(0));
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (s_ack_o != '0) acks++;
      step();
    end
    chk("rst no ack", 64'(acks), 64'(0));
    set_req(1, 1, 32'h6001, 32'h61);
    set_req(3, 1, 32'h6003, 32'h63);
    step();
    n = -1;
    for (int i = 0; i < 20 && n < 0; i++) begin
      if (s_ack_o != '0) n = ack_idx(s_ack_o);
      m_ack_i = 1'b1;
      step();
    end
    chk("rst rr restart", 64'(n), 64'(1));

    // Randomized traffic: no-ack stretches force timeouts, busy stretches force overflows.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int mode = (i / 250) % 3;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) begin
          int kind = $urandom_range(2);
          if (kind != 1) s_wen_i[k] = 1'b1;
          if (kind != 0) s_ren_i[k] = 1'b1;
          s_addr_i[k*AW +: AW]  = $urandom;
          s_wdata_i[k*DW +: DW] = $urandom;
        end
      end
      m_rdata_i = $urandom;
      if (mode == 1) m_ack_i = ($urandom_range(3) == 0);
      if (mode == 2) m_ack_i = ($urandom_range(1) == 0);
      if (mode != 0) m_err_i = ($urandom_range(7) == 0);
      rst_i = ($urandom_range(699) == 0);
      step();
      rst_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
